// File: rtl/rv_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_arb_pkg : shared types and port IDs for the memory-port arbiter    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package rv_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   localparam logic PORT_IF  = 1'b0;
   localparam logic PORT_LSU = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rv_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_rr_pick2 : combinational 2-way round-robin picker                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rv_rr_pick2
   import rv_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_id
);

   always_comb begin
      gnt_valid = |req;
      // On a tie the port that did not win last time goes first.
      if (req == 2'b11) begin
         gnt_id = ~last;
      end else begin
         gnt_id = req[1] ? PORT_LSU : PORT_IF;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rv_mem_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_mem_arb2 : two-port round-robin memory arbiter, one outstanding    |
// |               transaction, with response-timeout watchdog            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rv_mem_arb2
   import rv_arb_pkg::*;
#(
   parameter int AW      = 64,
   parameter int DW      = 64,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_valid,
   output logic          r0_ready,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   input  logic          r0_we,
   output logic          r0_rsp_valid,
   output logic [DW-1:0] r0_rdata,
   output logic          r0_err,
   input  logic          r1_valid,
   output logic          r1_ready,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   input  logic          r1_we,
   output logic          r1_rsp_valid,
   output logic [DW-1:0] r1_rdata,
   output logic          r1_err,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   output logic          m_we,
   input  logic          m_rsp_valid,
   input  logic [DW-1:0] m_rdata,
   output logic          sel
);

   localparam int                 c_cnt_w    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;

   arb_state_t         r_state;
   logic               r_sel;
   logic               r_last;
   logic [c_cnt_w-1:0] r_cnt;
   logic [AW-1:0]      r_addr;
   logic [DW-1:0]      r_wdata;
   logic               r_we;
   logic [1:0]         r_rsp_valid;
   logic [1:0]         r_err;
   logic [DW-1:0]      r_rdata [2];

   logic               w_gnt_valid;
   logic               w_gnt_id;
   logic               w_accept;
   logic               w_timeout;

   rv_rr_pick2 u_pick (
      .req       ({r1_valid, r0_valid}),
      .last      (r_last),
      .gnt_valid (w_gnt_valid),
      .gnt_id    (w_gnt_id)
   );

   assign w_accept  = (r_state == IDLE) && w_gnt_valid;
   // Firing on the last eligible cycle lets the error pulse land exactly TIMEOUT cycles after WAIT entry.
   assign w_timeout = (TIMEOUT > 0) && (r_cnt == c_cnt_last);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_sel       <= PORT_IF;
         r_last      <= PORT_LSU;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_we        <= 1'b0;
         r_rsp_valid <= '0;
         r_err       <= '0;
         r_rdata[0]  <= '0;
         r_rdata[1]  <= '0;
      end else begin
         r_rsp_valid <= '0;
         r_err       <= '0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr  <= w_gnt_id ? r1_addr  : r0_addr;
                  r_wdata <= w_gnt_id ? r1_wdata : r0_wdata;
                  r_we    <= w_gnt_id ? r1_we    : r0_we;
                  r_sel   <= w_gnt_id;
                  r_last  <= w_gnt_id;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_ready) begin
                  r_cnt   <= '0;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (m_rsp_valid) begin
                  r_rsp_valid[r_sel] <= 1'b1;
                  r_rdata[r_sel]     <= m_rdata;
                  r_state            <= IDLE;
               end else if (w_timeout) begin
                  r_rsp_valid[r_sel] <= 1'b1;
                  r_err[r_sel]       <= 1'b1;
                  r_rdata[r_sel]     <= '0;
                  r_state            <= IDLE;
               end else if (r_cnt != c_cnt_max) begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign r0_ready     = w_accept && (w_gnt_id == PORT_IF);
   assign r1_ready     = w_accept && (w_gnt_id == PORT_LSU);
   assign r0_rsp_valid = r_rsp_valid[0];
   assign r1_rsp_valid = r_rsp_valid[1];
   assign r0_err       = r_err[0];
   assign r1_err       = r_err[1];
   assign r0_rdata     = r_rdata[0];
   assign r1_rdata     = r_rdata[1];
   assign m_valid      = (r_state == ISSUE);
   assign m_addr       = r_addr;
   assign m_wdata      = r_wdata;
   assign m_we         = r_we;
   assign sel          = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv_mem_arb2 : randomized transaction-level bench for rv_mem_arb2  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_rv_mem_arb2;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          r0_valid, r0_ready, r0_we, r0_rsp_valid, r0_err;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata, r0_rdata;
   logic          r1_valid, r1_ready, r1_we, r1_rsp_valid, r1_err;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata, r1_rdata;
   logic          m_valid, m_ready, m_we, m_rsp_valid, sel;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;

   always #5 clk = ~clk;

   rv_mem_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_we(r0_we), .r0_rsp_valid(r0_rsp_valid), .r0_rdata(r0_rdata), .r0_err(r0_err),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_we(r1_we), .r1_rsp_valid(r1_rsp_valid), .r1_rdata(r1_rdata), .r1_err(r1_err),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_we(m_we), .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata), .sel(sel)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Requester-side pending requests (held until accepted)
   bit          pend [2];
   logic [63:0] q_addr [2];
   logic [63:0] q_wdata [2];
   logic        q_we [2];

   // Outstanding transaction, described by the cycles at which its events happen
   bit          act;
   int          t_port, t_acc, t_h, t_d;
   logic [63:0] t_addr, t_wdata;
   logic        t_we;

   int          last_win, exp_sel, win;
   int          pulse_cyc, pulse_port;
   bit          pulse_err;
   logic [63:0] pulse_data;
   logic [63:0] exp_rdata [2];
   bit          in_wait, exp_mv;
   int          r;

   initial begin
      rst_n = 1'b0;
      r0_valid = 0; r0_addr = '0; r0_wdata = '0; r0_we = 0;
      r1_valid = 0; r1_addr = '0; r1_wdata = '0; r1_we = 0;
      m_ready = 0; m_rsp_valid = 0; m_rdata = '0;
      repeat (3) @(negedge clk);

      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_sel", sel, 0);
      check_eq("rst_m_addr", m_addr, 0);
      check_eq("rst_m_we", m_we, 0);
      check_eq("rst_r0_rsp", {r0_rsp_valid, r0_err}, 0);
      check_eq("rst_r1_rsp", {r1_rsp_valid, r1_err}, 0);
      check_eq("rst_r0_rdata", r0_rdata, 0);
      check_eq("rst_r1_ready", {r0_ready, r1_ready}, 0);

      // Reset while a port-1 transaction sits in WAIT
      rst_n = 1'b1;
      r1_valid = 1; r1_addr = 64'h2000; r1_we = 1; r1_wdata = 64'h0123456789ABCDEF;
      #1;
      check_eq("dir_r1_ready", r1_ready, 1);
      check_eq("dir_r0_ready", r0_ready, 0);
      @(negedge clk);
      r1_valid = 0; m_ready = 1;
      check_eq("dir_m_valid", m_valid, 1);
      check_eq("dir_sel", sel, 1);
      check_eq("dir_m_addr", m_addr, 64'h2000);
      check_eq("dir_m_wdata", m_wdata, 64'h0123456789ABCDEF);
      @(negedge clk);
      m_ready = 0;
      check_eq("dir_wait_m_valid", m_valid, 0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("dir_rst_sel", sel, 0);
      check_eq("dir_rst_m_valid", m_valid, 0);
      check_eq("dir_rst_r1_rsp", {r1_rsp_valid, r1_err}, 0);
      m_rsp_valid = 1; m_rdata = 64'hDEADBEEFCAFEF00D;
      r1_valid = 1; r1_addr = 64'h3000; r1_we = 0;
      #1;
      check_eq("dir_new_r1_ready", r1_ready, 1);
      @(negedge clk);
      m_rsp_valid = 0; r1_valid = 0;
      check_eq("dir_late_rsp_r1", r1_rsp_valid, 0);
      check_eq("dir_late_rsp_r0", r0_rsp_valid, 0);
      check_eq("dir_late_rdata", r1_rdata, 0);
      check_eq("dir_new_m_addr", m_addr, 64'h3000);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Randomized run against the transaction-level model
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; exp_rdata[p] = '0; q_addr[p] = '0; q_wdata[p] = '0; q_we[p] = 0;
      end
      act = 0; t_port = 0; t_acc = 0; t_h = -1; t_d = -1; t_addr = '0; t_wdata = '0; t_we = 0;
      last_win = 1; exp_sel = 0;
      pulse_cyc = -1; pulse_port = 0; pulse_err = 0; pulse_data = '0;

      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (pulse_cyc == cyc) exp_rdata[pulse_port] = pulse_data;
         check_eq("sel", sel, exp_sel);
         exp_mv = act && (cyc > t_acc) && (t_h < 0);
         check_eq("m_valid", m_valid, exp_mv);
         if (exp_mv) begin
            check_eq("m_addr", m_addr, t_addr);
            check_eq("m_wdata", m_wdata, t_wdata);
            check_eq("m_we", m_we, t_we);
         end
         check_eq("r0_rsp_valid", r0_rsp_valid, pulse_cyc == cyc && pulse_port == 0);
         check_eq("r1_rsp_valid", r1_rsp_valid, pulse_cyc == cyc && pulse_port == 1);
         check_eq("r0_err", r0_err, pulse_cyc == cyc && pulse_port == 0 && pulse_err);
         check_eq("r1_err", r1_err, pulse_cyc == cyc && pulse_port == 1 && pulse_err);
         check_eq("r0_rdata", r0_rdata, exp_rdata[0]);
         check_eq("r1_rdata", r1_rdata, exp_rdata[1]);

         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 1) == 1) begin
               pend[p]    = 1;
               q_addr[p]  = {$urandom, $urandom};
               q_wdata[p] = {$urandom, $urandom};
               q_we[p]    = 1'($urandom_range(0, 1));
            end
         end
         r0_valid = pend[0]; r0_addr = q_addr[0]; r0_wdata = q_wdata[0]; r0_we = q_we[0];
         r1_valid = pend[1]; r1_addr = q_addr[1]; r1_wdata = q_wdata[1]; r1_we = q_we[1];
         m_ready = ($urandom_range(0, 4) < 2);
         in_wait = act && (t_h >= 0);
         if (in_wait) m_rsp_valid = (t_d >= 0) && (cyc == t_h + 1 + t_d);
         else         m_rsp_valid = ($urandom_range(0, 5) == 0);
         m_rdata = {$urandom, $urandom};
         #1;

         if (!act && (pend[0] || pend[1]))
            win = (pend[0] && pend[1]) ? 1 - last_win : (pend[1] ? 1 : 0);
         else
            win = -1;
         check_eq("r0_ready", r0_ready, win == 0);
         check_eq("r1_ready", r1_ready, win == 1);

         if (act && t_h < 0 && cyc > t_acc && m_ready) begin
            t_h = cyc;
            r = $urandom_range(0, 9);
            t_d = (r < 4) ? r : ((r < 7) ? TO - 1 : -1);
         end else if (in_wait) begin
            if (m_rsp_valid) begin
               pulse_cyc = cyc + 1; pulse_port = t_port; pulse_err = 0; pulse_data = m_rdata;
               act = 0;
            end else if (cyc == t_h + TO) begin
               pulse_cyc = cyc + 1; pulse_port = t_port; pulse_err = 1; pulse_data = '0;
               act = 0;
            end
         end
         if (win >= 0) begin
            act = 1; t_port = win; t_acc = cyc; t_h = -1; t_d = -1;
            t_addr = q_addr[win]; t_wdata = q_wdata[win]; t_we = q_we[win];
            pend[win] = 0; last_win = win; exp_sel = win;
         end
         @(posedge clk);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rv_mem_arb2.md
Name: rv_mem_arb2

Overview:
- Two-requester arbiter that shares one 64-bit memory port in the RV_Single core.
- Port 0 is instruction fetch; port 1 is load/store.
- Round-robin grant, one outstanding transaction at a time, with a response-timeout watchdog.
- Drives `sel` to the core's 2:1 64-bit address/data mux, so the mux follows the current owner.

Parameters:
- `AW`, 64, address width.
- `DW`, 64, data width.
- `TIMEOUT`, 255, cycles in WAIT before an error response is forced. 0 disables the timeout.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `r0_valid`  in  1  port 0 request valid.
- `r0_ready`  out  1  port 0 request accepted this cycle.
- `r0_addr`  in  AW  port 0 address.
- `r0_wdata`  in  DW  port 0 write data.
- `r0_we`  in  1  port 0 write enable.
- `r0_rsp_valid`  out  1  port 0 response pulse.
- `r0_rdata`  out  DW  port 0 read data.
- `r0_err`  out  1  port 0 timeout error, qualified by `r0_rsp_valid`.
- `r1_*`  same set as `r0_*`, for port 1.
- `m_valid`  out  1  memory request valid.
- `m_ready`  in  1  memory accepts request.
- `m_addr`  out  AW  memory address.
- `m_wdata`  out  DW  memory write data.
- `m_we`  out  1  memory write enable.
- `m_rsp_valid`  in  1  memory response valid.
- `m_rdata`  in  DW  memory read data.
- `sel`  out  1  current owner: 0 = port 0, 1 = port 1. Feeds the 2:1 mux select.

Behaviour:
- Reset (`rst_n`=0 at a clock edge):
  - state IDLE; `sel`=0; `last_grant`=1, so port 0 wins the first tie; timeout counter 0.
  - Latched addr/wdata/we cleared to 0.
  - All outputs 0.
  - Reset in ISSUE or WAIT abandons the transaction; no response is issued for it, and any later `m_rsp_valid` for it is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner computed combinationally from `r0_valid`/`r1_valid`.
  - If both are valid, the winner is the port != `last_grant`.
  - `rX_ready` = (state==IDLE) && winner==X. Both readies are 0 in ISSUE and WAIT.
  - On accept: latch addr/wdata/we; `sel`<=winner; `last_grant`<=winner; next state ISSUE.
- ISSUE:
  - `m_valid`=1; `m_addr`/`m_wdata`/`m_we` driven from the latched registers and held stable until `m_ready`.
  - On `m_valid`&&`m_ready`: next state WAIT, counter cleared.
- WAIT:
  - `m_valid`=0. Counter increments each cycle without `m_rsp_valid`.
  - On `m_rsp_valid`: `r[sel]_rsp_valid`<=1 for exactly one cycle; `r[sel]_rdata`<=`m_rdata`; `r[sel]_err`<=0; next state IDLE.
  - Timeout (TIMEOUT>0): WAIT entered at cycle W. If no `m_rsp_valid` in W..W+TIMEOUT-1, then at W+TIMEOUT: `rsp_valid`=1, `err`=1, `rdata`=0, state IDLE.
  - A response arriving at W+TIMEOUT-1 completes normally.
  - Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- `m_rsp_valid` in IDLE or ISSUE (spurious or late) is ignored.
- Response outputs are registered:
  - `rsp_valid` and `err` are 0 in every cycle except the single completion pulse.
  - `rdata` holds its last value between pulses.
  - The non-owning port's response outputs never pulse.
- Latency:
  - Accept at cycle N → `m_valid` at N+1.
  - `m_ready` at N+1 → WAIT at N+2.
  - `m_rsp_valid` at M → `rsp_valid` at M+1, with IDLE at M+1, so the next accept can happen at M+1.
- A requester must hold `valid` and its fields stable until `ready`. Dropping `valid` before `ready` simply withdraws the request.
- `sel` changes only on accept. It is stable through ISSUE, WAIT and the response pulse.

Decomposition:
- Package `rv_arb_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT}.
  - `localparam` port IDs `PORT_IF`=0 and `PORT_LSU`=1.
- Sub-module `rv_rr_pick2`: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_id.
- Everything else lives in `rv_mem_arb2`.

Test Plan:
1. Only `r0_valid`, addr 0x1000, `m_ready`=1, `m_rsp_valid` 3 cycles after accept with rdata 0xDEADBEEF_CAFEF00D → `m_addr`=0x1000 one cycle after accept; `r0_rsp_valid` one pulse with matching rdata, `r0_err`=0; `sel`=0; port 1 response outputs stay 0.
2. Both valid continuously from reset, memory with 1-cycle response → grant order 0,1,0,1 over four transactions; `sel` toggles only on accept; each port receives exactly 2 responses.
3. `r1` write, wdata 0x0123456789ABCDEF, `m_ready` held low 5 cycles → `m_valid` high for 6 cycles; `m_we`=1 and `m_wdata` stable throughout; `r0_ready`=0 throughout even with `r0_valid`=1.
4. TIMEOUT=8, no response → `r0_rsp_valid`=1, `r0_err`=1, `r0_rdata`=0 exactly 8 cycles after WAIT entry; a `m_rsp_valid` arriving 2 cycles later produces no pulse. Repeat with response at WAIT+7 → normal completion with `err`=0.
5. `rst_n`=0 for one cycle during WAIT → next cycle all outputs 0 and `sel`=0; the subsequent `m_rsp_valid` is ignored; a new `r1` request is accepted immediately.
6. `m_rsp_valid` pulsed while in IDLE and in ISSUE → no `rsp_valid` on either port; state and counter unaffected.
